scan_test_ctrl: RTL
===================

Name: scan_test_ctrl

Overview:
- Tester-side scan chain controller: the driving end of the scan_in_1 / scan_out_1 / scan_enable interface on the DFT top.
- Per pattern it does four things in order:
  - shifts a pattern into the chain;
  - pulses one functional capture cycle;
  - unloads the chain response;
  - compares the response against a masked expected value.
- Sits in the on-chip test wrapper next to the ALU/shifter top and drives its scan ports directly.

Parameters:
CHAIN_LEN, 5, number of scan flops in the chain (ALU F[3:0] + Cout)
CNT_W, 8, width of saturating fail counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock, synchronous reset, active-high, sampled on rising clk
start  input  1  request to run one pattern; accepted only in IDLE
skip_capture  input  1  sampled with start; 1 = omit capture cycle (chain integrity/loopback test)
pattern  input  CHAIN_LEN  stimulus to load, sampled with start
expected  input  CHAIN_LEN  golden response, sampled with start
mask  input  CHAIN_LEN  1 = compare bit, 0 = don't care, sampled with start
clear_count  input  1  synchronous clear of fail_count
busy  output  1  high from cycle after accepted start through DONE cycle
done  output  1  one-cycle pulse, response/pass valid
pass  output  1  masked compare result, held until next accepted start
response  output  CHAIN_LEN  unloaded chain contents, held until next accepted start
fail_count  output  CNT_W  saturating count of failed patterns
scan_enable  output  1  1 = chain in shift mode
scan_in_1  output  1  serial data into chain
scan_out_1  input  1  serial data from chain last flop

Behaviour:
- Reset:
  - state=IDLE; scan_enable=0, scan_in_1=0.
  - busy=0, done=0, pass=0, response=0, fail_count=0.
  - Bit counter and shift registers cleared.
  - Reset mid-operation aborts immediately, with no done pulse; the chain contents are left as-is.
- Outputs:
  - scan_enable, scan_in_1, busy and done are registered, decoded from state/shift regs only.
  - No combinational input-to-output path.
- IDLE: on start=1, latch pattern, expected, mask and skip_capture, load bit counter=0, go SHIFT_IN.
  - start in any other state is ignored; it is not queued.
- SHIFT_IN (CHAIN_LEN cycles):
  - scan_enable=1; scan_in_1 = pat_sr MSB; pat_sr shifts left each cycle.
  - The first bit shifted ends in the flop nearest scan_out_1.
  - After the last bit: go CAPTURE, or SHIFT_OUT if skip_capture.
- CAPTURE (1 cycle): scan_enable=0, scan_in_1=0; the chain loads functional values.
- SHIFT_OUT (CHAIN_LEN cycles):
  - scan_enable=1, scan_in_1=0.
  - Each rising edge: resp_sr <= {resp_sr[CHAIN_LEN-2:0], scan_out_1}, sampled on the same edge the chain shifts (pre-shift value).
  - The first unloaded bit ends in response MSB.
- DONE (1 cycle):
  - done=1, busy=1, scan_enable=0.
  - response=resp_sr; pass = ((resp_sr ^ expected) & mask) == 0.
  - On fail, fail_count+1, saturating at all-ones. Next state IDLE.
- Latency:
  - start accepted at edge 0; done high in cycle 2*CHAIN_LEN+2.
  - With skip_capture, done high in cycle 2*CHAIN_LEN+1.
- Back-to-back: start is accepted in the IDLE cycle after DONE, so the minimum period is 2*CHAIN_LEN+3 cycles.
- mask=0 gives pass=1 regardless of response.
- clear_count and an increment in the same cycle: the clear wins, and the result is 0.
- Bit counter width = clog2(CHAIN_LEN+1); it wraps only via reload in IDLE.

Decomposition:
- Package scan_test_pkg holds:
  - state enum (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE);
  - default CHAIN_LEN;
  - clog2 helper constant for the counter width.
- One natural sub-module: scan_shift_reg. It is a parameterised parallel-load, serial-in/serial-out shift register, instantiated twice (pattern and response).

Test Plan:
- Loopback (model chain = 5 flops, no functional logic), skip_capture=1, pattern=5'b10110 -> response=5'b10110, pass=1, done in cycle 11, scan_enable high cycles 1-10.
- Capture: model capture loads 5'b01101, pattern=5'b11111, expected=5'b01101, mask=5'b11111 -> pass=1; scan_enable=0 in cycle 6 only; done in cycle 12.
- Masked compare: captured 5'b01101, expected=5'b01100, mask=5'b11110 -> pass=1; same with mask=5'b11111 -> pass=0, fail_count=1.
- Counter: 256 failing patterns with CNT_W=8 -> fail_count saturates at 255; clear_count concurrent with the 257th fail -> fail_count=0.
- Reset at cycle 4 of SHIFT_IN -> next cycle scan_enable=0, busy=0, no done pulse; start in cycle 3 while busy ignored (single done observed).
- Back-to-back: start held high continuously -> done pulses every 13 cycles, response updates only on done.

Source files
------------

// File: rtl/scan_test_ctrl_pkg.sv
// Shared types and sizing helpers for the tester-side scan controller.
package scan_test_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_IN,
      CAPTURE,
      SHIFT_OUT,
      DONE
   } state_t;

   localparam int DEF_CHAIN_LEN = 5;

   function automatic int cnt_bits(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int DEF_BIT_W = cnt_bits(DEF_CHAIN_LEN);

endpackage

// File: rtl/scan_test_ctrl_shift_reg.sv
// Parallel-load, serial-in/serial-out shift register (MSB shifts out first).
module scan_shift_reg #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift,
   input  logic         ser_in,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= {q[W-2:0], ser_in};
      end
   end

endmodule

// File: rtl/scan_test_ctrl.sv
// Tester-side scan controller: shift in, capture, unload, masked compare.
module scan_test_ctrl
   import scan_test_pkg::*;
#(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 skip_capture,
   input  logic [CHAIN_LEN-1:0] pattern,
   input  logic [CHAIN_LEN-1:0] expected,
   input  logic [CHAIN_LEN-1:0] mask,
   input  logic                 clear_count,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CHAIN_LEN-1:0] response,
   output logic [CNT_W-1:0]     fail_count,
   output logic                 scan_enable,
   output logic                 scan_in_1,
   input  logic                 scan_out_1
);

   localparam int BW = cnt_bits(CHAIN_LEN);
   localparam logic [BW-1:0] LAST = BW'(CHAIN_LEN - 1);
   localparam logic [BW-1:0] ONE  = BW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t               state;
   state_t               state_nx;
   logic [BW-1:0]        cnt;
   logic [CHAIN_LEN-1:0] exp_q;
   logic [CHAIN_LEN-1:0] mask_q;
   logic [CHAIN_LEN-1:0] pat_q;
   logic [CHAIN_LEN-1:0] resp_q;
   logic [CHAIN_LEN-1:0] resp_nx;
   logic                 skip_q;
   logic                 accept;
   logic                 fin;
   logic                 pass_nx;
   logic                 pat_shift;
   logic                 resp_shift;
   logic                 unused_ok;

   assign accept     = (state == IDLE) && start;
   assign pat_shift  = (state == SHIFT_IN);
   assign resp_shift = (state == SHIFT_OUT);
   assign fin        = resp_shift && (cnt == ONE);
   assign resp_nx    = {resp_q[CHAIN_LEN-2:0], scan_out_1};
   assign pass_nx    = ((resp_nx ^ exp_q) & mask_q) == '0;
   assign unused_ok  = ^{pat_q[CHAIN_LEN-2:0], resp_q[CHAIN_LEN-1]};

   scan_shift_reg #(.W(CHAIN_LEN)) u_pat (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .load_val (pattern),
      .shift    (pat_shift),
      .ser_in   (1'b0),
      .q        (pat_q)
   );

   scan_shift_reg #(.W(CHAIN_LEN)) u_resp (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .load_val ({CHAIN_LEN{1'b0}}),
      .shift    (resp_shift),
      .ser_in   (scan_out_1),
      .q        (resp_q)
   );

   always_comb begin
      state_nx    = state;
      scan_enable = 1'b0;
      scan_in_1   = 1'b0;
      busy        = (state != IDLE);
      done        = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nx = SHIFT_IN;
         end
         SHIFT_IN: begin
            scan_enable = 1'b1;
            scan_in_1   = pat_q[CHAIN_LEN-1];
            if (cnt == LAST) state_nx = skip_q ? SHIFT_OUT : CAPTURE;
         end
         CAPTURE: begin
            state_nx = SHIFT_OUT;
         end
         SHIFT_OUT: begin
            scan_enable = 1'b1;
            if (cnt == ONE) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // cnt climbs to CHAIN_LEN while loading, then counts back down while
   // unloading, so it never wraps and needs no reload between phases.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         exp_q      <= '0;
         mask_q     <= '0;
         skip_q     <= 1'b0;
         response   <= '0;
         pass       <= 1'b0;
         fail_count <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cnt    <= '0;
            exp_q  <= expected;
            mask_q <= mask;
            skip_q <= skip_capture;
         end else if (pat_shift) begin
            cnt <= cnt + ONE;
         end else if (resp_shift) begin
            cnt <= cnt - ONE;
         end
         if (fin) begin
            response <= resp_nx;
            pass     <= pass_nx;
         end
         if (clear_count) begin
            fail_count <= '0;
         end else if (fin && !pass_nx && (fail_count != '1)) begin
            fail_count <= fail_count + CNT_ONE;
         end
      end
   end

endmodule
